// File: rtl/quadtest_mem_arbiter.sv
// quadtest_mem_arbiter: two-requester round-robin arbiter onto one single-cycle-latency memory port.
// Optional grant locking is built when QUADTEST_ARB_LOCK_EN is defined.
module quadtest_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
`ifdef QUADTEST_ARB_LOCK_EN
  , parameter int LOCK_MAX = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
`ifdef QUADTEST_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   rv0_q, rv0_d, rv1_q, rv1_d, oor_q, oor_d;
  logic   req0, req1, base0, base1, gnt0, gnt1, gnt, sel_wr, in_range;
  logic [ADDR_W-1:0] sel_addr;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  // prio_q=1 means m1 wins the next contention
  assign base0 = req0 & (~req1 | ~prio_q);
  assign base1 = req1 & ~base0;

`ifdef QUADTEST_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          hold_q, hold_d, held0, held1, sel_lock;
  logic [CW-1:0] cnt_q, cnt_d;

  assign held0    = hold_q & (state_q == OWN0) & req0;
  assign held1    = hold_q & (state_q == OWN1) & req1;
  assign gnt0     = reset_n & (held0 | (~held1 & base0));
  assign gnt1     = reset_n & (held1 | (~held0 & base1));
  assign sel_lock = gnt0 ? m0_lock : m1_lock;

  // the lock lapses on an unlocked transfer, an idle owner, or LOCK_MAX locked transfers
  always_comb begin
    cnt_d  = '0;
    hold_d = 1'b0;
    if (gnt && sel_lock) begin
      cnt_d  = ((held0 | held1) ? cnt_q : '0) + 1'b1;
      hold_d = cnt_d != CW'(LOCK_MAX);
      if (!hold_d) cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  logic state_unused;

  assign gnt0         = reset_n & base0;
  assign gnt1         = reset_n & base1;
  assign state_unused = ^state_q;
`endif

  assign gnt      = gnt0 | gnt1;
  assign sel_addr = gnt0 ? m0_address : m1_address;
  assign sel_wr   = gnt0 ? m0_write : m1_write;
  assign in_range = {1'b0, sel_addr} < DEPTH_L;

  assign mem_address    = sel_addr;
  assign mem_byteenable = gnt0 ? m0_byteenable : m1_byteenable;
  assign mem_writedata  = gnt0 ? m0_writedata : m1_writedata;
  assign mem_chipselect = gnt & in_range;
  assign mem_write      = mem_chipselect & sel_wr;
  assign mem_clken      = reset_n;

  assign m0_waitrequest   = ~reset_n | (req0 & ~gnt0);
  assign m1_waitrequest   = ~reset_n | (req1 & ~gnt1);
  assign m0_readdatavalid = rv0_q;
  assign m1_readdatavalid = rv1_q;
  assign m0_readdata      = (rv0_q & ~oor_q) ? mem_readdata : '0;
  assign m1_readdata      = (rv1_q & ~oor_q) ? mem_readdata : '0;

  // read+write together counts as a write, so no read-valid is scheduled
  always_comb begin
    state_d = gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
    prio_d  = gnt0 ? 1'b1 : gnt1 ? 1'b0 : prio_q;
    rv0_d   = gnt0 & m0_read & ~m0_write;
    rv1_d   = gnt1 & m1_read & ~m1_write;
    oor_d   = ~in_range;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      oor_q   <= oor_d;
    end
  end
endmodule

// File: tb/tb_quadtest_mem_arbiter.sv
// tb_quadtest_mem_arbiter: vector table plus read scoreboard against a behavioural memory.
// Lock scenario is included when QUADTEST_ARB_LOCK_EN is defined.
module tb_quadtest_mem_arbiter;
  localparam int AW = 13;
  localparam int DEPTH = 5120;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init_mem = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0]   m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]   m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic [31:0]   mem_writedata, mem_rd;
  logic          mem_chipselect, mem_write, mem_clken;
`ifdef QUADTEST_ARB_LOCK_EN
  logic          m0_lock = 1'b0, m1_lock = 1'b0;
`endif

  quadtest_mem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
`ifdef QUADTEST_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_rd)
  );

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // behavioural single-cycle-latency memory
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_rd <= ram[mem_address];
      end
    end
  end

  logic [31:0] shadow [0:DEPTH-1];

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rd_t;
  rd_t sb[$];

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic ew0, ew1, ecs, ewr;
  } vec_t;
  vec_t vt[$];

  int passed = 0;
  int total = 0;

  function automatic vec_t mk(int r0, int w0, int a0, int be0, int d0,
                              int r1, int w1, int a1, int be1, int d1,
                              int ew0, int ew1, int ecs, int ewr);
    vec_t v;
    v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = AW'(a0); v.be0 = 4'(be0); v.d0 = 32'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = AW'(a1); v.be1 = 4'(be1); v.d1 = 32'(d1);
    v.ew0 = 1'(ew0); v.ew1 = 1'(ew1); v.ecs = 1'(ecs); v.ewr = 1'(ewr);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model(input logic p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (w) begin
      if (int'(a) < DEPTH)
        for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    end else if (r) begin
      sb.push_back('{p, (int'(a) < DEPTH) ? shadow[a] : 32'h0});
    end
  endtask

  task automatic check_rd(input string tag);
    rd_t e;
    logic ev0 = 1'b0, ev1 = 1'b0;
    logic [31:0] ed0 = '0, ed1 = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port) begin ev1 = 1'b1; ed1 = e.data; end
      else begin ev0 = 1'b1; ed0 = e.data; end
    end
    chk({tag, " rdv0"}, 32'(m0_readdatavalid), 32'(ev0));
    chk({tag, " rdv1"}, 32'(m1_readdatavalid), 32'(ev1));
    chk({tag, " rdata0"}, m0_readdata, ed0);
    chk({tag, " rdata1"}, m1_readdata, ed1);
  endtask

  task automatic drive(input vec_t v);
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.d0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.d1;
  endtask

  task automatic apply(input vec_t v, input int id);
    string tag;
    tag = $sformatf("v%0d", id);
    @(negedge clk);
    drive(v);
    #1;
    check_rd(tag);
    chk({tag, " wait0"}, 32'(m0_waitrequest), 32'(v.ew0));
    chk({tag, " wait1"}, 32'(m1_waitrequest), 32'(v.ew1));
    chk({tag, " cs"}, 32'(mem_chipselect), 32'(v.ecs));
    chk({tag, " mwr"}, 32'(mem_write), 32'(v.ewr));
    if ((v.r0 | v.w0) && !v.ew0) model(1'b0, v.r0, v.w0, v.a0, v.be0, v.d0);
    if ((v.r1 | v.w1) && !v.ew1) model(1'b1, v.r1, v.w1, v.a1, v.be1, v.d1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
    // contention: alternating grants, m0 first after reset
    vt.push_back(mk(1,0,'h100,0,0, 1,0,'h200,0,0, 0,1,1,0));
    vt.push_back(mk(1,0,'h101,0,0, 1,0,'h200,0,0, 1,0,1,0));
    vt.push_back(mk(1,0,'h101,0,0, 1,0,'h201,0,0, 0,1,1,0));
    vt.push_back(mk(1,0,'h102,0,0, 1,0,'h201,0,0, 1,0,1,0));
    vt.push_back(mk(1,0,'h102,0,0, 1,0,'h202,0,0, 0,1,1,0));
    vt.push_back(mk(1,0,'h103,0,0, 1,0,'h202,0,0, 1,0,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    // single-port write then read-back
    vt.push_back(mk(0,1,'h010,'hF,'hDEADBEEF, 0,0,0,0,0, 0,0,1,1));
    vt.push_back(mk(1,0,'h010,0,0, 0,0,0,0,0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    // read+write together acts as write; then byte-lane merge
    vt.push_back(mk(1,1,'h004,'hF,'h12345678, 0,0,0,0,0, 0,0,1,1));
    vt.push_back(mk(1,0,'h004,0,0, 0,0,0,0,0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,1,'h004,'h3,'hAAAABBBB, 0,0,1,1));
    vt.push_back(mk(0,0,0,0,0, 1,0,'h004,0,0, 0,0,1,0));
    // out-of-range and top in-range addresses
    vt.push_back(mk(0,0,0,0,0, 1,0,5120,0,0, 0,0,0,0));
    vt.push_back(mk(0,0,0,0,0, 0,1,8191,'hF,'hFFFFFFFF, 0,0,0,0));
    vt.push_back(mk(0,0,0,0,0, 1,0,5119,0,0, 0,0,1,0));
    // write vs read contention on one address
    vt.push_back(mk(0,1,'h020,'hF,'h0BADF00D, 1,0,'h020,0,0, 0,1,1,1));
    vt.push_back(mk(0,0,0,0,0, 1,0,'h020,0,0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));

    m0_read = 1'b1; m1_write = 1'b1;
    @(negedge clk); #1;
    chk("rst wait0", 32'(m0_waitrequest), 32'h1);
    chk("rst wait1", 32'(m1_waitrequest), 32'h1);
    chk("rst cs", 32'(mem_chipselect), 32'h0);
    chk("rst mwr", 32'(mem_write), 32'h0);
    chk("rst clken", 32'(mem_clken), 32'h0);
    check_rd("rst");
    init_mem = 1'b0;
    m0_read = 1'b0; m1_write = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    #1;
    chk("run clken", 32'(mem_clken), 32'h1);

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i + 1);

    // read accepted right before a mid-cycle reset must not complete
    @(negedge clk);
    m0_read = 1'b1; m0_address = 'h010;
    #1;
    chk("pre-rst wait0", 32'(m0_waitrequest), 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b0; m0_read = 1'b0;
    #1;
    chk("in-rst rdv0", 32'(m0_readdatavalid), 32'h0);
    chk("in-rst wait0", 32'(m0_waitrequest), 32'h1);
    @(negedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_rd($sformatf("post-rst%0d", i));
    end
    @(negedge clk);
    m0_read = 1'b1; m0_address = 'h020; m1_read = 1'b1; m1_address = 'h030;
    #1;
    chk("post-rst wait0", 32'(m0_waitrequest), 32'h0);
    chk("post-rst wait1", 32'(m1_waitrequest), 32'h1);
    model(1'b0, 1'b1, 1'b0, 'h020, 4'h0, 32'h0);
    @(negedge clk);
    m0_read = 1'b0;
    #1;
    check_rd("post-rst m0 data");
    chk("post-rst wait1b", 32'(m1_waitrequest), 32'h0);
    model(1'b1, 1'b1, 1'b0, 'h030, 4'h0, 32'h0);
    @(negedge clk);
    m1_read = 1'b0;
    #1;
    check_rd("post-rst m1 data");

`ifdef QUADTEST_ARB_LOCK_EN
    begin
      int k = 0;
      logic m1_done = 1'b0;
      logic ew0, ew1;
      for (int c = 1; c <= 21; c++) begin
        @(negedge clk);
        m0_write = 1'b1; m0_lock = 1'b1; m0_byteenable = 4'hF;
        m0_address = AW'('h300 + k); m0_writedata = 32'(k);
        m1_write = (c >= 2) && !m1_done; m1_address = 'h3FF;
        m1_byteenable = 4'hF; m1_writedata = 32'h1111_2222;
        #1;
        ew0 = (c == 17);
        ew1 = (c >= 2) && (c < 17);
        chk($sformatf("lock c%0d wait0", c), 32'(m0_waitrequest), 32'(ew0));
        chk($sformatf("lock c%0d wait1", c), 32'(m1_waitrequest), 32'(ew1));
        if (!ew0) k++;
        if (c == 17) m1_done = 1'b1;
      end
      @(negedge clk);
      m0_write = 1'b0; m0_lock = 1'b0; m1_write = 1'b0;
      #1;
      chk("lock release wait1", 32'(m1_waitrequest), 32'h0);
    end
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/quadtest_mem_arbiter.md
QUADTEST_MEM_ARBITER -- requirements
Module: quadtest_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: word-address width of both requester ports and the memory port.
REQ-002 Parameter DEPTH, default 5120: number of implemented 32-bit words in the attached memory.
REQ-003 Parameter LOCK_MAX, default 16: maximum consecutive locked transfers per owner; present only with the lock feature.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 m0_address / m1_address  in  ADDR_W  requester word address.
REQ-007 m0_read / m1_read  in  1  read request.
REQ-008 m0_write / m1_write  in  1  write request.
REQ-009 m0_byteenable / m1_byteenable  in  4  write byte lanes.
REQ-010 m0_writedata / m1_writedata  in  32  write data.
REQ-011 m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
REQ-012 m0_readdata / m1_readdata  out  32  read data.
REQ-013 m0_readdatavalid / m1_readdatavalid  out  1  readdata qualifier.
REQ-014 m0_lock / m1_lock  in  1  hold grant after this transfer; present only with the lock feature.
REQ-015 mem_address  out  ADDR_W, mem_byteenable  out  4, mem_writedata  out  32: memory port.
REQ-016 mem_chipselect  out  1, mem_write  out  1, mem_clken  out  1, mem_readdata  in  32: memory port.

Function
REQ-017 A port requests when read or write is high; read and write both high SHALL be treated as a write only, with no readdatavalid.
REQ-018 FSM states IDLE, OWN0, OWN1; at most one access is issued to memory per cycle.
REQ-019 Without lock, arbitration SHALL occur every cycle: a single requester wins; on contention, the port not granted last wins (round-robin; after reset, m0 wins).
REQ-020 The winning access SHALL drive mem_* combinationally in the same cycle; winner waitrequest=0; a pending loser has waitrequest=1 and SHALL hold its request.
REQ-021 A non-requesting port SHALL see waitrequest=0.
REQ-022 mem_clken SHALL be 1 whenever reset_n=1; mem_chipselect=1 only for an issued in-range access; mem_write=1 only for an issued in-range write.
REQ-023 An accepted read SHALL produce readdatavalid=1 on its port exactly 1 cycle later, with readdata=mem_readdata; the other port's readdatavalid stays 0.
REQ-024 Back-to-back reads SHALL sustain 1 read per cycle, and each readdatavalid SHALL be routed to its own issuing port.
REQ-025 Address >= DEPTH: a write is accepted and dropped (mem_chipselect=0); a read is accepted and returns readdata=0 with readdatavalid one cycle later.
REQ-026 readdata SHALL be 0 whenever readdatavalid=0.
REQ-027 The FSM SHALL be in OWNn in the cycle after port n is granted, and in IDLE after a cycle with no grant.

Reset
REQ-028 reset_n low SHALL asynchronously clear the FSM to IDLE, the round-robin pointer to m0, pending read-valid flags and the lock counter.
REQ-029 While reset_n=0: waitrequest=1 on both ports; readdatavalid=0; readdata=0; mem_chipselect=0; mem_write=0; mem_clken=0.
REQ-030 A read accepted in the cycle before reset assertion SHALL NOT produce readdatavalid after reset release.

Configuration
REQ-031 Macro QUADTEST_ARB_LOCK_EN: when defined, m0_lock/m1_lock and LOCK_MAX exist.
REQ-032 With the macro defined, an accepted transfer with lock=1 SHALL keep the FSM in OWNn; the other port is refused until the owner issues an accepted transfer with lock=0, goes one cycle without requesting, or completes LOCK_MAX consecutive locked transfers.
REQ-033 On hitting LOCK_MAX with the other port pending, the other port SHALL be granted in the next cycle and the counter SHALL clear.
REQ-034 With the macro undefined, the ports and the counter are absent and REQ-019 applies unconditionally.

Verification
REQ-035 Only m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then reads it -> waitrequest=0 on both, readdata=0xDEADBEEF with readdatavalid 1 cycle after the read.
REQ-036 m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,...; each port receives 3 readdatavalid pulses with correct data.
REQ-037 m1 reads address 5120 -> mem_chipselect=0; m1_readdata=0 with readdatavalid next cycle; m1 writes address 8191 -> no mem_write.
REQ-038 m0 read accepted, reset_n pulsed low mid-cycle -> no readdatavalid after release; first contention after release grants m0.
REQ-039 Lock build: m0 issues 20 locked writes while m1 is pending -> m1 granted on transfer 17 (after 16 locked m0 transfers).
REQ-040 m0 asserts read and write together at address 0x0004 -> write performed, no m0_readdatavalid.
